led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED driver and the successor to the fixed free-running-counter blinker.
- Each of NUM_LEDS channels is independently programmable as OFF, ON, BLINK (programmable half-period) or BREATHE (triangular PWM ramp).
- A shared prescaler produces a slow timebase tick. A shared free-running counter provides PWM.
- Sits at top level between board clock and LED pins; mode/period inputs come from switches or a control block.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, timebase tick rate. DIV = CLK_HZ/TICK_HZ must be >= 2; elaboration error otherwise.
- NUM_LEDS, 2, number of channels (>= 1).
- PWM_BITS, 8, PWM resolution; PWM_MAX = 2^PWM_BITS-1.
- HP_BITS, 16, width of per-channel half_period field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 freezes all state.
- mode  in  2*NUM_LEDS  per channel, slice [2i+1:2i]: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- half_period  in  HP_BITS*NUM_LEDS  per channel: ticks per BLINK phase, or per BREATHE level step.
- duty  in  PWM_BITS*NUM_LEDS  per channel brightness used in ON mode.
- led  out  NUM_LEDS  registered LED drive, 1 = lit.
- tick  out  1  registered 1-cycle timebase pulse.

Behaviour:
- Reset (rst_n low, async): prescaler, pwm_cnt, all channel cnt/phase/level = 0; dir = up; prev_mode = 0; led = 0; tick = 0. First count occurs on the first clk edge after rst_n deasserts.
- Prescaler:
  - Counts 0..DIV-1 while en=1; wraps to 0.
  - tick = 1 for exactly the cycle after the count equals DIV-1, so it has a period of DIV cycles.
  - While en=0: prescaler holds, tick = 0.
- PWM counter: PWM_BITS wide, +1 every cycle while en=1, wraps PWM_MAX->0. pwm(x) = (pwm_cnt < x).
- Per-channel step divider:
  - Active in modes 2 and 3. On each tick: if cnt >= hp_eff-1, set cnt = 0 and assert step for that tick; else cnt+1.
  - hp_eff = max(half_period, 1).
  - Using >= means a half_period reduced below the current cnt fires on the next tick; no lock-up.
- Mode behaviour (led registered, 1-cycle latency from the internal state):
  - OFF: led = 0.
  - ON: led = pwm(duty).
    - duty = 0 gives constant 0.
    - duty = PWM_MAX gives high except 1 cycle per 2^PWM_BITS.
  - BLINK: on step, phase toggles; led = phase. The first lit phase begins after hp_eff ticks.
  - BREATHE: on step, level moves by 1 in direction dir.
    - On the step that makes level reach PWM_MAX, dir becomes down. On the step that makes it reach 0, dir becomes up.
    - level never wraps. led = pwm(level).
- Mode change: when a channel's mode differs from its registered prev_mode, that channel's cnt, phase and level are set to 0 and dir to up on that edge; prev_mode updates. Other channels are unaffected.
- Simultaneous events:
  - A mode change in the same cycle as a tick takes priority; the tick is ignored for that channel.
  - en=0 in the same cycle as a tick: state is frozen and led holds its last value.
  - Mode change while en=0 is applied on the first enabled cycle.
- Reset mid-operation: immediate clear of all outputs regardless of clk.

Test Plan:
- CLK_HZ=100, TICK_HZ=10, NUM_LEDS=2, PWM_BITS=4; release rst_n -> tick pulses 1 cycle every 10 cycles, first at cycle 10 after release; led = 00 until modes set.
- ch0 BLINK, half_period=3 -> led[0] toggles every 30 cycles (3 ticks); half_period=0 -> toggles every tick.
- ch1 ON, duty = 0/5/15 -> led[1] high 0/5/15 cycles per 16.
- ch1 BREATHE, half_period=1 -> level steps 0..15 over 15 ticks, 15..0 over 15 ticks, repeats; no wrap past 15 or 0.
- ch0 BLINK mid-phase, then switch to BREATHE and back -> cnt/phase cleared; the next toggle occurs exactly half_period ticks after the switch; ch1 pattern is undisturbed.
- en=0 for 25 cycles mid-BLINK -> no ticks and led frozen; after re-enable the remaining phase length is unchanged. Async rst_n pulse between clk edges -> led = 0 immediately.

Source files
------------

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver with OFF/ON(PWM)/BLINK/BREATHE modes
// A shared prescaler tick paces per-channel step dividers; a shared free-running counter drives PWM.
module led_pattern_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 2,
  parameter int PWM_BITS = 8,
  parameter int HP_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2*NUM_LEDS-1:0]        mode,
  input  logic [HP_BITS*NUM_LEDS-1:0]  half_period,
  input  logic [PWM_BITS*NUM_LEDS-1:0] duty,
  output logic [NUM_LEDS-1:0]          led,
  output logic                         tick
);

  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int PRESC_BITS = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(DIV - 1);
  localparam logic [PWM_BITS-1:0]   PWM_MAX    = '1;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  if (DIV < 2) begin : g_div_check
    $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PRESC_BITS-1:0] presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick_now;

  // Channels advance on the same edge that raises the registered tick, so a tick is never lost to en.
  assign tick_now = en && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      presc   <= (presc == PRESC_LAST) ? '0 : presc + PRESC_BITS'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      tick    <= (presc == PRESC_LAST);
    end else begin
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic [1:0]          ch_mode;
    logic [1:0]          prev_mode;
    logic [HP_BITS-1:0]  hp;
    logic [HP_BITS-1:0]  hp_last;
    logic [HP_BITS-1:0]  cnt;
    logic [PWM_BITS-1:0] ch_duty;
    logic [PWM_BITS-1:0] level;
    logic                phase;
    logic                dir_down;
    logic                led_q;
    logic                step;

    assign ch_mode = mode[2*i +: 2];
    assign hp      = half_period[HP_BITS*i +: HP_BITS];
    assign ch_duty = duty[PWM_BITS*i +: PWM_BITS];
    // half_period of 0 behaves as 1; >= lets a shrunken period fire on the next tick.
    assign hp_last = (hp == '0) ? '0 : hp - HP_BITS'(1);
    assign step    = cnt >= hp_last;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_mode <= MODE_OFF;
        cnt       <= '0;
        phase     <= 1'b0;
        level     <= '0;
        dir_down  <= 1'b0;
        led_q     <= 1'b0;
      end else if (en) begin
        if (ch_mode != prev_mode) begin
          prev_mode <= ch_mode;
          cnt       <= '0;
          phase     <= 1'b0;
          level     <= '0;
          dir_down  <= 1'b0;
        end else if (tick_now && (prev_mode == MODE_BLINK || prev_mode == MODE_BREATHE)) begin
          cnt <= step ? '0 : cnt + HP_BITS'(1);
          if (step) begin
            if (prev_mode == MODE_BLINK) begin
              phase <= ~phase;
            end else if (!dir_down) begin
              level <= level + PWM_BITS'(1);
              if (level == PWM_MAX - PWM_BITS'(1)) dir_down <= 1'b1;
            end else begin
              level <= level - PWM_BITS'(1);
              if (level == PWM_BITS'(1)) dir_down <= 1'b0;
            end
          end
        end

        case (prev_mode)
          MODE_OFF:     led_q <= 1'b0;
          MODE_ON:      led_q <= pwm_cnt < ch_duty;
          MODE_BLINK:   led_q <= phase;
          MODE_BREATHE: led_q <= pwm_cnt < level;
          default:      led_q <= 1'b0;
        endcase
      end
    end

    assign led[i] = led_q;
  end

endmodule
